noc_vc_output_arbiter: RTL and testbench

Credit-based output scheduler for one router output port. It shares the single output link among CHANNELS per-VC input FIFOs using round-robin arbitration, and gates each VC on downstream credits. Optional packet locking keeps packets contiguous. It sits between the per-VC FIFO bank on the input side and the link/crossbar output, and registers the granted flit in one output stage.

---
 rtl/noc_vc_output_arbiter_pkg.sv | 22 ++
 rtl/noc_rr_arbiter.sv | 43 ++++
 rtl/noc_vc_output_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_noc_vc_output_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_vc_output_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// noc_vc_output_arbiter_pkg
// Shared types and constants for the VC output arbiter and its round-robin
// helper.
//   lock_state_e    : packet-lock FSM states
//   DEFAULT_CREDITS : reset credit count used when CREDITS is not overridden
//   wrap_idx()      : folds an index in [0, 2n) back into [0, n)
// ---------------------------------------------------------------------------
package noc_vc_output_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    localparam int DEFAULT_CREDITS = 32;

    function automatic int wrap_idx(input int a, input int n);
        return (a >= n) ? (a - n) : a;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// noc_rr_arbiter
// Combinational round-robin arbiter. The request at index i_ptr has the
// highest priority; priority then falls upward with wrap-around.
// Ports:
//   i_req       in  N      request vector
//   i_ptr       in  IDX_W  index of the highest-priority requester
//   o_grant     out N      one-hot grant (all zero when no request)
//   o_grant_idx out IDX_W  index of the granted requester
//   o_grant_vld out 1      at least one request was granted
// ---------------------------------------------------------------------------
module noc_rr_arbiter
    import noc_vc_output_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_vld
);

    logic [IDX_W-1:0] w_idx;

    // Walk the requesters starting at i_ptr; the first hit wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IDX_W'(wrap_idx(int'(i_ptr) + k, N));
            if (!o_grant_vld && i_req[w_idx]) begin
                o_grant_vld    = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/noc_vc_output_arbiter.sv
// ---------------------------------------------------------------------------
// noc_vc_output_arbiter
// Credit-based output scheduler for one router output port. Shares the link
// among CHANNELS per-VC FIFO heads by round-robin, gates each VC on its
// downstream credit count, optionally locks the port to one VC for the whole
// packet, and registers the granted flit in a single output stage.
// Ports:
//   noc_clk, noc_rst_n   clock, asynchronous active-low reset
//   in_valid/in_flit     per-VC FIFO head valid and flit (flit i at [i*FLIT_W +: FLIT_W])
//   in_head/in_tail      per-VC packet head / tail markers
//   in_ready             one-hot pop to the granted FIFO (combinational)
//   out_valid/out_flit   registered flit and its valid
//   out_vc               VC index of out_flit
//   out_ready            link accepts the current flit
//   credit_valid/_vc     one credit returned for VC credit_vc
//   credit_err           sticky: credit returned to an already-full counter
// ---------------------------------------------------------------------------
module noc_vc_output_arbiter
    import noc_vc_output_arbiter_pkg::*;
#(
    parameter int CHANNELS    = 32,
    parameter int FLIT_W      = 64,
    parameter int CREDITS     = DEFAULT_CREDITS,
    parameter int LOCK_PACKET = 0,
    parameter int VC_W        = $clog2(CHANNELS)
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    input  logic [CHANNELS-1:0]        in_valid,
    input  logic [CHANNELS*FLIT_W-1:0] in_flit,
    input  logic [CHANNELS-1:0]        in_head,
    input  logic [CHANNELS-1:0]        in_tail,
    output logic [CHANNELS-1:0]        in_ready,
    output logic                       out_valid,
    output logic [FLIT_W-1:0]          out_flit,
    output logic [VC_W-1:0]            out_vc,
    input  logic                       out_ready,
    input  logic                       credit_valid,
    input  logic [VC_W-1:0]            credit_vc,
    output logic                       credit_err
);

    localparam int              CNT_W   = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  r_credit [CHANNELS];
    logic              r_credit_err;
    logic [VC_W-1:0]   r_rr_ptr;
    lock_state_e       r_lock_state;
    logic [VC_W-1:0]   r_lock_vc;
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_flit;
    logic [VC_W-1:0]   r_out_vc;

    logic                w_load;
    logic [CHANNELS-1:0] w_eligible;
    logic [CHANNELS-1:0] w_req;
    logic [CHANNELS-1:0] w_grant_oh;
    logic [VC_W-1:0]     w_grant_idx;
    logic                w_grant_vld;
    logic                w_grant_head;
    logic                w_grant_tail;
    logic [FLIT_W-1:0]   w_grant_flit;
    logic [CHANNELS-1:0] w_ret;
    logic [CHANNELS-1:0] w_over;

    // The output stage can take a new flit when empty or being drained.
    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_eligible[i] = in_valid[i] && (r_credit[i] != '0);
            if (r_lock_state == LOCKED && VC_W'(i) != r_lock_vc) begin
                w_eligible[i] = 1'b0;
            end
        end
    end

    // Reset also masks requests so in_ready stays low while the reset is held.
    assign w_req = (w_load && noc_rst_n) ? w_eligible : '0;

    noc_rr_arbiter #(
        .N     (CHANNELS),
        .IDX_W (VC_W)
    ) u_rr_arbiter (
        .i_req       (w_req),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    assign in_ready     = w_grant_oh;
    assign w_grant_head = |(in_head & w_grant_oh);
    assign w_grant_tail = |(in_tail & w_grant_oh);

    always_comb begin
        w_grant_flit = '0;
        w_ret        = '0;
        w_over       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant_oh[i]) begin
                w_grant_flit = in_flit[i*FLIT_W +: FLIT_W];
            end
            w_ret[i]  = credit_valid && (credit_vc == VC_W'(i));
            // A return that is not cancelled by a same-cycle grant overflows a full counter.
            w_over[i] = w_ret[i] && !w_grant_oh[i] && (r_credit[i] == CNT_MAX);
        end
    end

    // Credit counters: grant takes one, return gives one, both cancel out.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_credit[i] <= CNT_MAX;
            end
            r_credit_err <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_grant_oh[i] && !w_ret[i]) begin
                    r_credit[i] <= r_credit[i] - CNT_ONE;
                end else if (w_ret[i] && !w_grant_oh[i] && !w_over[i]) begin
                    r_credit[i] <= r_credit[i] + CNT_ONE;
                end
            end
            if (|w_over) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_vc    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_grant_vld;
                if (w_grant_vld) begin
                    r_out_flit <= w_grant_flit;
                    r_out_vc   <= w_grant_idx;
                end
            end
            if (w_grant_vld) begin
                r_rr_ptr <= (w_grant_idx == VC_W'(CHANNELS - 1)) ? '0 : w_grant_idx + VC_W'(1);
            end
        end
    end

    // Packet lock: a multi-flit head claims the port until its tail leaves.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_lock_state <= IDLE;
            r_lock_vc    <= '0;
        end else if (LOCK_PACKET != 0 && w_grant_vld) begin
            case (r_lock_state)
                IDLE: begin
                    if (w_grant_head && !w_grant_tail) begin
                        r_lock_state <= LOCKED;
                        r_lock_vc    <= w_grant_idx;
                    end
                end
                LOCKED: begin
                    if (w_grant_tail) begin
                        r_lock_state <= IDLE;
                    end
                end
                default: r_lock_state <= IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_flit   = r_out_flit;
    assign out_vc     = r_out_vc;
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_noc_vc_output_arbiter.sv
module tb_noc_vc_output_arbiter;

    localparam int CH = 8;
    localparam int FW = 32;
    localparam int CR = 4;
    localparam int VW = 3;

    logic             noc_clk = 1'b0;
    logic             noc_rst_n = 1'b1;
    logic [CH-1:0]    in_valid;
    logic [CH*FW-1:0] in_flit;
    logic [CH-1:0]    in_head;
    logic [CH-1:0]    in_tail;
    logic [CH-1:0]    in_ready;
    logic             out_valid;
    logic [FW-1:0]    out_flit;
    logic [VW-1:0]    out_vc;
    logic             out_ready;
    logic             credit_valid;
    logic [VW-1:0]    credit_vc;
    logic             credit_err;

    noc_vc_output_arbiter #(
        .CHANNELS    (CH),
        .FLIT_W      (FW),
        .CREDITS     (CR),
        .LOCK_PACKET (1),
        .VC_W        (VW)
    ) dut (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .in_valid     (in_valid),
        .in_flit      (in_flit),
        .in_head      (in_head),
        .in_tail      (in_tail),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_vc       (out_vc),
        .out_ready    (out_ready),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .credit_err   (credit_err)
    );

    always #5 noc_clk = ~noc_clk;

    typedef struct packed {
        logic [FW-1:0] flit;
        logic          head;
        logic          tail;
    } flit_t;

    typedef struct packed {
        logic          valid;
        logic [VW-1:0] vc;
        logic [FW-1:0] flit;
    } ostate_t;

    // Per-VC source FIFOs, scoreboard of output-register states, accepted-VC log,
    // and downstream buffer holding VCs whose credits are still outstanding.
    flit_t   vcq [CH][$];
    ostate_t exp_q [$];
    int      acc_log [$];
    int      dq [$];

    // Reference model state
    int            m_cred [CH];
    int            m_rr;
    int            m_lock;
    bit            m_err;
    bit            m_ov;
    int            m_vc;
    logic [FW-1:0] m_flit;

    bit            auto_credit;
    bit            man_cv;
    int            man_cvc;
    logic [CH-1:0] vmask;
    bit            mon_en;
    int            seq;
    int            n_cmp;
    int            n_fail;
    ostate_t       mon_st;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_pkt(input int vc, input int len);
        flit_t f;
        for (int j = 0; j < len; j++) begin
            f.flit = {8'(vc), 24'(seq)};
            f.head = (j == 0);
            f.tail = (j == len - 1);
            seq++;
            vcq[vc].push_back(f);
        end
    endtask

    task automatic check_log(input string nm, input int req[8], input int n);
        chk({nm, "_len"}, 64'(acc_log.size()), 64'(n));
        for (int j = 0; j < n; j++) begin
            if (j < acc_log.size()) chk(nm, 64'(acc_log[j]), 64'(req[j]));
        end
    endtask

    // One clock cycle: drive FIFO heads and credits, predict the grant from the
    // arbitration rules, check in_ready, update the model, advance the clock.
    task automatic tick();
        int      g;
        bit      load;
        ostate_t st;
        logic [CH-1:0] exp_rdy;
        for (int i = 0; i < CH; i++) begin
            if (vcq[i].size() > 0 && vmask[i]) begin
                in_valid[i]         = 1'b1;
                in_flit[i*FW +: FW] = vcq[i][0].flit;
                in_head[i]          = vcq[i][0].head;
                in_tail[i]          = vcq[i][0].tail;
            end else begin
                in_valid[i]         = 1'b0;
                in_flit[i*FW +: FW] = '0;
                in_head[i]          = 1'b0;
                in_tail[i]          = 1'b0;
            end
        end
        if (man_cv) begin
            credit_valid = 1'b1;
            credit_vc    = VW'(man_cvc);
            man_cv       = 1'b0;
        end else if (auto_credit && dq.size() > 0 && $urandom_range(0, 1) == 1) begin
            credit_valid = 1'b1;
            credit_vc    = VW'(dq.pop_front());
        end else begin
            credit_valid = 1'b0;
            credit_vc    = '0;
        end
        #1;
        chk("credit_err", 64'(credit_err), 64'(m_err));
        load = !m_ov || out_ready;
        g = -1;
        if (load) begin
            for (int k = 0; k < CH; k++) begin
                int i;
                i = (m_rr + k) % CH;
                if (g < 0 && in_valid[i] && m_cred[i] > 0 && (m_lock < 0 || m_lock == i)) g = i;
            end
        end
        exp_rdy = (g >= 0) ? (CH'(1) << g) : '0;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (m_ov && out_ready) dq.push_back(m_vc);
        if (load) begin
            if (g >= 0) begin
                m_ov   = 1'b1;
                m_vc   = g;
                m_flit = vcq[g][0].flit;
            end else begin
                m_ov = 1'b0;
            end
            st.valid = m_ov;
            st.vc    = VW'(m_vc);
            st.flit  = m_flit;
            exp_q.push_back(st);
        end
        if (g >= 0) m_cred[g]--;
        if (credit_valid) begin
            if (m_cred[credit_vc] == CR) m_err = 1'b1;
            else m_cred[credit_vc]++;
        end
        if (g >= 0) begin
            if (m_lock < 0 && vcq[g][0].head && !vcq[g][0].tail) m_lock = g;
            else if (m_lock == g && vcq[g][0].tail) m_lock = -1;
            m_rr = (g + 1) % CH;
            void'(vcq[g].pop_front());
        end
        @(posedge noc_clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        noc_rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_flit", 64'(out_flit), 64'(0));
        chk("rst_out_vc", 64'(out_vc), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_credit_err", 64'(credit_err), 64'(0));
        for (int i = 0; i < CH; i++) vcq[i].delete();
        in_valid     = '0;
        in_flit      = '0;
        in_head      = '0;
        in_tail      = '0;
        credit_valid = 1'b0;
        credit_vc    = '0;
        dq.delete();
        @(posedge noc_clk);
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        for (int i = 0; i < CH; i++) m_cred[i] = CR;
        m_rr   = 0;
        m_lock = -1;
        m_err  = 1'b0;
        m_ov   = 1'b0;
        m_vc   = 0;
        m_flit = '0;
        man_cv = 1'b0;
        exp_q.delete();
        mon_st = '0;
        exp_q.push_back(mon_st);
        acc_log.delete();
        mon_en = 1'b1;
    endtask

    // Monitor: the scoreboard front is the state the output register must hold now.
    always @(negedge noc_clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                mon_st = exp_q[0];
                chk("out_valid", 64'(out_valid), 64'(mon_st.valid));
                if (mon_st.valid) begin
                    chk("out_vc", 64'(out_vc), 64'(mon_st.vc));
                    chk("out_flit", 64'(out_flit), 64'(mon_st.flit));
                end
                if (mon_st.valid && out_ready) acc_log.push_back(int'(mon_st.vc));
                if (!mon_st.valid || out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int c;
        int v;
        in_valid     = '0;
        in_flit      = '0;
        in_head      = '0;
        in_tail      = '0;
        out_ready    = 1'b1;
        credit_valid = 1'b0;
        credit_vc    = '0;
        vmask        = '1;
        auto_credit  = 1'b1;
        man_cv       = 1'b0;
        man_cvc      = 0;
        mon_en       = 1'b0;
        seq          = 0;
        n_cmp        = 0;
        n_fail       = 0;

        // Reset with all VCs idle
        #2;
        do_reset();
        repeat (10) tick();

        // Round-robin over VCs 0, 3, 5 with single-flit packets
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_pkt(0, 1);
            push_pkt(3, 1);
            push_pkt(5, 1);
        end
        repeat (7) tick();
        check_log("rr_seq", '{0, 3, 5, 0, 3, 5, 0, 0}, 6);
        repeat (3) tick();

        // Credit exhaustion, single credit release, same-cycle grant and return
        do_reset();
        auto_credit = 1'b0;
        repeat (6) push_pkt(2, 1);
        repeat (12) tick();
        check_log("credit_stop", '{2, 2, 2, 2, 0, 0, 0, 0}, 4);
        man_cv = 1'b1; man_cvc = 2;
        tick();
        man_cv = 1'b1; man_cvc = 2;
        tick();
        repeat (6) tick();
        chk("credit_net_zero_cnt", 64'(acc_log.size()), 64'(6));
        push_pkt(2, 1);
        push_pkt(2, 1);
        repeat (6) tick();
        chk("credit_drained_cnt", 64'(acc_log.size()), 64'(6));

        // Credit returned to a full counter
        man_cv = 1'b1; man_cvc = 7;
        tick();
        tick();
        chk("credit_err_sticky", 64'(credit_err), 64'(1));
        repeat (5) push_pkt(7, 1);
        repeat (10) tick();
        c = 0;
        foreach (acc_log[j]) if (acc_log[j] == 7) c++;
        chk("full_counter_flits", 64'(c), 64'(4));

        // Packet lock with a mid-packet output stall
        do_reset();
        auto_credit = 1'b1;
        push_pkt(1, 4);
        push_pkt(4, 1);
        push_pkt(4, 1);
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        out_ready = 1'b1;
        repeat (8) tick();
        check_log("lock_seq", '{1, 1, 1, 1, 4, 4, 0, 0}, 6);

        // Reset in the middle of a locked packet
        do_reset();
        push_pkt(1, 4);
        tick();
        tick();
        do_reset();
        push_pkt(0, 1);
        push_pkt(4, 1);
        repeat (4) tick();
        check_log("post_reset_seq", '{0, 4, 0, 0, 0, 0, 0, 0}, 2);

        // Randomized traffic against the model
        do_reset();
        auto_credit = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < CH; i++) vmask[i] = ($urandom_range(0, 99) < 85);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0) begin
                v = $urandom_range(0, CH - 1);
                if (vcq[v].size() < 8) push_pkt(v, $urandom_range(1, 4));
            end
            tick();
        end
        vmask     = '1;
        out_ready = 1'b1;
        repeat (80) tick();
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
